// File: rtl/round_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : round_sequencer_pkg
// Brief    : Shared state encodings, right-of-way/winner codes and timing
//            constants for the match/round sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package round_sequencer_pkg;

    localparam int CLK_HZ  = 65_000_000;
    localparam int TIMER_W = 25;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FIGHT   = 3'd1;
    localparam logic [2:0] S_CLASH   = 3'd2;
    localparam logic [2:0] S_KILL    = 3'd3;
    localparam logic [2:0] S_RESPAWN = 3'd4;
    localparam logic [2:0] S_ADVANCE = 3'd5;
    localparam logic [2:0] S_WIN     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_FIGHT   = S_FIGHT,
        ST_CLASH   = S_CLASH,
        ST_KILL    = S_KILL,
        ST_RESPAWN = S_RESPAWN,
        ST_ADVANCE = S_ADVANCE,
        ST_WIN     = S_WIN
    } state_t;

    // Right-of-way and winner share one encoding
    localparam logic [1:0] ROW_NONE = 2'b00;
    localparam logic [1:0] ROW_L    = 2'b01;
    localparam logic [1:0] ROW_R    = 2'b10;

    // One board step towards +lim (up=1) or -lim (up=0), saturating at the limit
    function automatic logic signed [3:0] idx_step(input logic signed [3:0] idx,
                                                   input logic              up,
                                                   input logic signed [3:0] lim);
        logic signed [3:0] res;
        res = idx;
        if (up) begin
            if (idx != lim) res = idx + 4'sd1;
        end else begin
            if (idx != -lim) res = idx - 4'sd1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/round_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : round_sequencer_if
// Brief    : Event inputs and match outputs of the round sequencer.
//            SCORE_EN adds the kills_L/kills_R score counters.
// Revision : 1.0 - initial release
// ============================================================================
interface round_sequencer_if;

    logic              start;
    logic              dead_L;
    logic              dead_R;
    logic              collision;
    logic              exit_L;
    logic              exit_R;
    logic              freeze;
    logic              pos_reset;
    logic [1:0]        right_of_way;
    logic signed [3:0] board_idx;
    logic [1:0]        winner;
    logic [2:0]        state_dbg;
`ifdef SCORE_EN
    logic [7:0]        kills_L;
    logic [7:0]        kills_R;
`endif

`ifdef SCORE_EN
    modport master (
        output start, dead_L, dead_R, collision, exit_L, exit_R,
        input  freeze, pos_reset, right_of_way, board_idx, winner, state_dbg,
        input  kills_L, kills_R
    );
    modport slave (
        input  start, dead_L, dead_R, collision, exit_L, exit_R,
        output freeze, pos_reset, right_of_way, board_idx, winner, state_dbg,
        output kills_L, kills_R
    );
`else
    modport master (
        output start, dead_L, dead_R, collision, exit_L, exit_R,
        input  freeze, pos_reset, right_of_way, board_idx, winner, state_dbg
    );
    modport slave (
        input  start, dead_L, dead_R, collision, exit_L, exit_R,
        output freeze, pos_reset, right_of_way, board_idx, winner, state_dbg
    );
`endif

endinterface
`default_nettype wire

// File: rtl/round_sequencer_hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : hold_timer
// Brief    : Loadable down-counter that stops at zero; done while at zero.
// Revision : 1.0 - initial release
// ============================================================================
module hold_timer #(
    parameter int WIDTH = 25
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] value,
    output logic                  done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : round_sequencer
// Brief    : Match/round FSM: turns hit/clash/exit events into freeze,
//            respawn, right-of-way, board index and winner.
//            Define SCORE_EN to add saturating per-player kill counters.
// Revision : 1.0 - initial release
// ============================================================================
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int KILL_HOLD    = 32_500_000,
    parameter int CLASH_HOLD   = 6_500_000,
    parameter int RESPAWN_HOLD = 13_000_000,
    parameter int BOARD_MAX    = 3
) (
    input  wire logic         clk,
    input  wire logic         reset,
    round_sequencer_if.slave  bus
);

    // A hold of N cycles loads N-1 so the state is occupied for exactly N cycles
    localparam logic [TIMER_W-1:0] c_kill_load    = TIMER_W'(KILL_HOLD - 1);
    localparam logic [TIMER_W-1:0] c_clash_load   = TIMER_W'(CLASH_HOLD - 1);
    localparam logic [TIMER_W-1:0] c_respawn_load = TIMER_W'(RESPAWN_HOLD - 1);
    localparam logic signed [3:0]  c_idx_max      = 4'(BOARD_MAX);
    localparam logic signed [3:0]  c_idx_min      = -c_idx_max;

    state_t            r_state;
    logic              r_freeze;
    logic              r_pos_reset;
    logic [1:0]        r_row;
    logic signed [3:0] r_board_idx;
    logic [1:0]        r_winner;

    logic               w_adv_L;
    logic               w_adv_R;
    logic               w_kill;
    logic               w_done;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_value;

    assign w_adv_L = bus.exit_L && (r_row == ROW_L);
    assign w_adv_R = bus.exit_R && (r_row == ROW_R);
    assign w_kill  = bus.dead_L || bus.dead_R;

    // Timer is loaded on the same edge that enters a timed state
    always_comb begin
        w_load       = 1'b0;
        w_load_value = '0;
        case (r_state)
            ST_IDLE, ST_WIN: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_load_value = c_respawn_load;
                end
            end
            ST_FIGHT: begin
                if (!(w_adv_L || w_adv_R)) begin
                    if (w_kill) begin
                        w_load       = 1'b1;
                        w_load_value = c_kill_load;
                    end else if (bus.collision) begin
                        w_load       = 1'b1;
                        w_load_value = c_clash_load;
                    end
                end
            end
            ST_KILL: begin
                if (w_done) begin
                    w_load       = 1'b1;
                    w_load_value = c_respawn_load;
                end
            end
            ST_ADVANCE: begin
                if ((r_board_idx != c_idx_max) && (r_board_idx != c_idx_min)) begin
                    w_load       = 1'b1;
                    w_load_value = c_respawn_load;
                end
            end
            default: ;
        endcase
    end

    hold_timer #(
        .WIDTH (TIMER_W)
    ) u_hold_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .value (w_load_value),
        .done  (w_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_freeze    <= 1'b1;
            r_pos_reset <= 1'b1;
            r_row       <= ROW_NONE;
            r_board_idx <= '0;
            r_winner    <= ROW_NONE;
        end else begin
            case (r_state)
                ST_IDLE, ST_WIN: begin
                    if (bus.start) begin
                        r_state     <= ST_RESPAWN;
                        r_freeze    <= 1'b1;
                        r_pos_reset <= 1'b1;
                        r_row       <= ROW_NONE;
                        r_board_idx <= '0;
                        r_winner    <= ROW_NONE;
                    end
                end
                ST_FIGHT: begin
                    // Exit beats kill beats clash
                    if (w_adv_L) begin
                        r_state     <= ST_ADVANCE;
                        r_freeze    <= 1'b1;
                        r_board_idx <= idx_step(r_board_idx, 1'b1, c_idx_max);
                    end else if (w_adv_R) begin
                        r_state     <= ST_ADVANCE;
                        r_freeze    <= 1'b1;
                        r_board_idx <= idx_step(r_board_idx, 1'b0, c_idx_max);
                    end else if (w_kill) begin
                        r_state  <= ST_KILL;
                        r_freeze <= 1'b1;
                        if (bus.dead_L && bus.dead_R) r_row <= ROW_NONE;
                        else if (bus.dead_R)          r_row <= ROW_L;
                        else                          r_row <= ROW_R;
                    end else if (bus.collision) begin
                        r_state  <= ST_CLASH;
                        r_freeze <= 1'b1;
                    end
                end
                ST_CLASH: begin
                    if (w_done) begin
                        r_state  <= ST_FIGHT;
                        r_freeze <= 1'b0;
                    end
                end
                ST_KILL: begin
                    if (w_done) begin
                        r_state     <= ST_RESPAWN;
                        r_pos_reset <= 1'b1;
                    end
                end
                ST_RESPAWN: begin
                    if (w_done) begin
                        r_state     <= ST_FIGHT;
                        r_freeze    <= 1'b0;
                        r_pos_reset <= 1'b0;
                    end
                end
                ST_ADVANCE: begin
                    if (r_board_idx == c_idx_max) begin
                        r_state  <= ST_WIN;
                        r_winner <= ROW_L;
                    end else if (r_board_idx == c_idx_min) begin
                        r_state  <= ST_WIN;
                        r_winner <= ROW_R;
                    end else begin
                        r_state     <= ST_RESPAWN;
                        r_pos_reset <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.freeze       = r_freeze;
    assign bus.pos_reset    = r_pos_reset;
    assign bus.right_of_way = r_row;
    assign bus.board_idx    = r_board_idx;
    assign bus.winner       = r_winner;
    assign bus.state_dbg    = r_state;

`ifdef SCORE_EN
    logic       r_kills_L;
    logic [7:0] r_kills_L_cnt;
    logic [7:0] r_kills_R_cnt;
    logic       w_kill_evt;
    logic       w_start_acc;

    assign r_kills_L   = 1'b0;
    assign w_kill_evt  = (r_state == ST_FIGHT) && !(w_adv_L || w_adv_R) && w_kill;
    assign w_start_acc = ((r_state == ST_IDLE) || (r_state == ST_WIN)) && bus.start;

    // The survivor scores: dead_R credits L, dead_L credits R
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kills_L_cnt <= '0;
            r_kills_R_cnt <= '0;
        end else if (w_start_acc) begin
            r_kills_L_cnt <= '0;
            r_kills_R_cnt <= '0;
        end else if (w_kill_evt) begin
            if (bus.dead_R && (r_kills_L_cnt != 8'hFF)) r_kills_L_cnt <= r_kills_L_cnt + 8'd1;
            if (bus.dead_L && (r_kills_R_cnt != 8'hFF)) r_kills_R_cnt <= r_kills_R_cnt + 8'd1;
        end
    end

    assign bus.kills_L = r_kills_L_cnt;
    assign bus.kills_R = r_kills_R_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_sequencer
// Brief    : Directed self-checking bench for round_sequencer with short holds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_round_sequencer;

    localparam int E_IDLE = 0, E_FIGHT = 1, E_CLASH = 2, E_KILL = 3,
                   E_RESPAWN = 4, E_ADVANCE = 5, E_WIN = 6;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    round_sequencer_if bus ();

    round_sequencer #(
        .KILL_HOLD    (8),
        .CLASH_HOLD   (4),
        .RESPAWN_HOLD (3),
        .BOARD_MAX    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic s, input logic dl, input logic dr,
                        input logic col, input logic el, input logic er);
        bus.start = s; bus.dead_L = dl; bus.dead_R = dr;
        bus.collision = col; bus.exit_L = el; bus.exit_R = er;
        tick();
        bus.start = 0; bus.dead_L = 0; bus.dead_R = 0;
        bus.collision = 0; bus.exit_L = 0; bus.exit_R = 0;
    endtask

    task automatic expect_outs(input string tag, input int st, input logic frz,
                               input logic prst, input logic [1:0] row,
                               input logic [3:0] idx, input logic [1:0] win);
        check({tag, "/state"},     {29'd0, bus.state_dbg},    st);
        check({tag, "/freeze"},    {31'd0, bus.freeze},       {31'd0, frz});
        check({tag, "/pos_reset"}, {31'd0, bus.pos_reset},    {31'd0, prst});
        check({tag, "/row"},       {30'd0, bus.right_of_way}, {30'd0, row});
        check({tag, "/board_idx"}, {28'd0, bus.board_idx},    {28'd0, idx});
        check({tag, "/winner"},    {30'd0, bus.winner},       {30'd0, win});
    endtask

    task automatic expect_kills(input string tag, input int kl, input int kr);
`ifdef SCORE_EN
        check({tag, "/kills_L"}, {24'd0, bus.kills_L}, kl);
        check({tag, "/kills_R"}, {24'd0, bus.kills_R}, kr);
`else
        if (kl < 0 || kr < 0) $display("%s: negative kill count requested", tag);
`endif
    endtask

    // Entered RESPAWN on the previous tick; two more RESPAWN cycles, then FIGHT
    task automatic respawn_to_fight(input string tag);
        repeat (2) begin
            tick();
            check({tag, "/respawn_state"}, {29'd0, bus.state_dbg}, E_RESPAWN);
            check({tag, "/respawn_prst"},  {31'd0, bus.pos_reset}, 1);
        end
        tick();
        check({tag, "/fight_state"},  {29'd0, bus.state_dbg}, E_FIGHT);
        check({tag, "/fight_freeze"}, {31'd0, bus.freeze},     0);
        check({tag, "/fight_prst"},   {31'd0, bus.pos_reset},  0);
    endtask

    // Entered KILL on the previous tick; seven more KILL cycles, then respawn
    task automatic kill_to_fight(input string tag);
        repeat (7) begin
            tick();
            check({tag, "/kill_state"},  {29'd0, bus.state_dbg}, E_KILL);
            check({tag, "/kill_freeze"}, {31'd0, bus.freeze},    1);
        end
        tick();
        check({tag, "/to_respawn"}, {29'd0, bus.state_dbg}, E_RESPAWN);
        check({tag, "/to_respawn_prst"}, {31'd0, bus.pos_reset}, 1);
        respawn_to_fight(tag);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus.start = 0; bus.dead_L = 0; bus.dead_R = 0;
        bus.collision = 0; bus.exit_L = 0; bus.exit_R = 0;

        // Reset and first start
        repeat (3) tick();
        expect_outs("reset", E_IDLE, 1, 1, 2'b00, 4'h0, 2'b00);
        expect_kills("reset", 0, 0);
        reset = 1'b1;
        tick();
        check("idle_hold", {29'd0, bus.state_dbg}, E_IDLE);
        step(1, 0, 0, 0, 0, 0);
        expect_outs("start", E_RESPAWN, 1, 1, 2'b00, 4'h0, 2'b00);
        respawn_to_fight("start");

        // Exits without right of way are ignored
        step(0, 0, 0, 0, 0, 1);
        expect_outs("exitR_norow", E_FIGHT, 0, 0, 2'b00, 4'h0, 2'b00);

        // R hit: L gets right of way
        step(0, 0, 1, 0, 0, 0);
        expect_outs("deadR", E_KILL, 1, 0, 2'b01, 4'h0, 2'b00);
        expect_kills("deadR", 1, 0);
        kill_to_fight("deadR");

        step(0, 0, 0, 0, 0, 1);
        expect_outs("exitR_rowL", E_FIGHT, 0, 0, 2'b01, 4'h0, 2'b00);

        // L advances twice and wins
        step(0, 0, 0, 0, 1, 0);
        expect_outs("advL1", E_ADVANCE, 1, 0, 2'b01, 4'h1, 2'b00);
        tick();
        expect_outs("advL1_resp", E_RESPAWN, 1, 1, 2'b01, 4'h1, 2'b00);
        respawn_to_fight("advL1");
        step(0, 0, 0, 0, 1, 0);
        expect_outs("advL2", E_ADVANCE, 1, 0, 2'b01, 4'h2, 2'b00);
        tick();
        expect_outs("winL", E_WIN, 1, 0, 2'b01, 4'h2, 2'b01);
        step(0, 0, 1, 0, 1, 0);
        expect_outs("winL_hold", E_WIN, 1, 0, 2'b01, 4'h2, 2'b01);

        // Restart from WIN clears board, winner, right of way and scores
        step(1, 0, 0, 0, 0, 0);
        expect_outs("restart", E_RESPAWN, 1, 1, 2'b00, 4'h0, 2'b00);
        expect_kills("restart", 0, 0);
        respawn_to_fight("restart");

        // Clash holds four cycles
        step(0, 0, 0, 1, 0, 0);
        expect_outs("clash", E_CLASH, 1, 0, 2'b00, 4'h0, 2'b00);
        repeat (3) begin
            tick();
            check("clash_hold", {29'd0, bus.state_dbg}, E_CLASH);
        end
        tick();
        expect_outs("clash_end", E_FIGHT, 0, 0, 2'b00, 4'h0, 2'b00);

        // Double kill
        step(0, 1, 1, 0, 0, 0);
        expect_outs("double", E_KILL, 1, 0, 2'b00, 4'h0, 2'b00);
        expect_kills("double", 1, 1);
        kill_to_fight("double");

        // L hit: R gets right of way
        step(0, 1, 0, 0, 0, 0);
        expect_outs("deadL", E_KILL, 1, 0, 2'b10, 4'h0, 2'b00);
        expect_kills("deadL", 1, 2);
        kill_to_fight("deadL");

        // Exit has priority over a simultaneous kill
        step(0, 1, 0, 0, 0, 1);
        expect_outs("prio_exit", E_ADVANCE, 1, 0, 2'b10, 4'hF, 2'b00);
        expect_kills("prio_exit", 1, 2);
        tick();
        check("prio_resp", {29'd0, bus.state_dbg}, E_RESPAWN);
        respawn_to_fight("prio");

        // Asynchronous reset in the middle of a clash
        step(0, 0, 0, 1, 0, 0);
        expect_outs("clash2", E_CLASH, 1, 0, 2'b10, 4'hF, 2'b00);
        #2;
        reset = 1'b0;
        #1;
        expect_outs("async_rst", E_IDLE, 1, 1, 2'b00, 4'h0, 2'b00);
        expect_kills("async_rst", 0, 0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_idle", {29'd0, bus.state_dbg}, E_IDLE);

        // R walks to -BOARD_MAX and wins; board index saturates
        step(1, 0, 0, 0, 0, 0);
        respawn_to_fight("start2");
        step(0, 1, 0, 0, 0, 0);
        expect_outs("deadL2", E_KILL, 1, 0, 2'b10, 4'h0, 2'b00);
        kill_to_fight("deadL2");
        step(0, 0, 0, 0, 0, 1);
        expect_outs("advR1", E_ADVANCE, 1, 0, 2'b10, 4'hF, 2'b00);
        tick();
        respawn_to_fight("advR1");
        step(0, 0, 0, 0, 0, 1);
        expect_outs("advR2", E_ADVANCE, 1, 0, 2'b10, 4'hE, 2'b00);
        tick();
        expect_outs("winR", E_WIN, 1, 0, 2'b10, 4'hE, 2'b10);
        step(0, 0, 0, 0, 0, 1);
        expect_outs("winR_hold", E_WIN, 1, 0, 2'b10, 4'hE, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
